instr_fetch_ctrl: RTL

Fetch sequencer for the 24-bit instruction ROM (1024 words, synchronous 1-cycle read). It owns the program counter and drives the ROM address. It hides the ROM read latency behind a 2-entry output buffer and delivers `{pc, instr}` to decode over a valid/ready handshake. It also pre-decodes unconditional jumps and HALT, and accepts branch redirects from execute.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 24;

    localparam logic [INSTR_W-1:0] HALT_WORD = 24'h000000;
    localparam logic [3:0]         OP_JMP    = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry shifting output buffer; the head register drives decode directly.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t ent0_q, ent1_q, ent0_d, ent1_d;
    logic         v0_q, v1_q, v0_d, v1_d;

    // Pop shifts the second slot forward, then a push fills the first free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            if (pop && v0_q) begin
                ent0_d = ent1_q;
                v0_d   = v1_q;
                v1_d   = 1'b0;
            end
            if (push) begin
                if (!v0_d) begin
                    ent0_d = push_data;
                    v0_d   = 1'b1;
                end else begin
                    ent1_d = push_data;
                    v1_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
        end
    end

    assign head       = ent0_q;
    assign head_valid = v0_q;
    assign count      = 2'(v0_q) + 2'(v1_q);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM, pre-decodes jumps/HALT and
// delivers {pc, instr} to decode through a two-entry buffer.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = PC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic              busy_d, halted_d;

    fetch_entry_t      head, push_data;
    logic [1:0]        count;
    logic              pop, redir_ok, cap_halt, cap_jmp, issue;
    logic [2:0]        occupancy;

    assign pop       = out_valid & out_ready;
    assign redir_ok  = redirect_valid & ((state_q == RUN) | (state_q == STOP));
    assign cap_halt  = inflight_q & (rom_instr == HALT_WORD);
    assign cap_jmp   = inflight_q & (rom_instr[23:20] == OP_JMP);
    assign occupancy = 3'(count) + 3'(inflight_q);
    assign issue     = (state_q == RUN) && (occupancy < 3'd2 + 3'(pop));
    assign push_data = '{pc: PC_W'(fetch_pc_q), instr: rom_instr};

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redir_ok),
        .head       (head),
        .head_valid (out_valid),
        .count      (count)
    );

    // Later assignments win: redirect over jump/HALT over plain issue.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        if (issue) begin
            pc_d       = pc_q + ADDR_W'(1);
            fetch_pc_d = pc_q;
            inflight_d = 1'b1;
        end
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                pc_d    = ADDR_W'(RESET_PC);
            end
            RUN:     if (cap_halt) state_d = STOP;
            STOP:    if (count == 2'd0) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (cap_jmp) begin
            pc_d       = rom_instr[ADDR_W-1:0];
            inflight_d = 1'b0;
        end
        if (cap_halt) inflight_d = 1'b0;
        if (redir_ok) begin
            state_d    = RUN;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
        end
        busy_d   = (state_d == RUN) || (state_d == STOP);
        halted_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            fetch_pc_q <= '0;
            inflight_q <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            busy       <= busy_d;
            halted     <= halted_d;
        end
    end

    assign rom_addr  = pc_q;
    assign out_instr = head.instr;
    assign out_pc    = ADDR_W'(head.pc);

endmodule
